q78_arith: RTL and testbench
============================

Q78_ARITH -- requirements
Module: q78_arith

Interface
REQ-001 Parameter SATURATE, default 1: 1 = clamp overflowing results to the signed 16-bit range; 0 = keep the low 16 bits (wrap).
REQ-002 Parameter ROUND, default 1: 1 = multiply rounds to nearest, ties toward +inf; 0 = multiply truncates (arithmetic shift, floor).
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operands valid this cycle; captured into output registers.
REQ-006 mul_a, mul_b  in  16 each  signed Q7.8 multiplier operands.
REQ-007 add_a, add_b  in  16 each  signed Q7.8 adder operands.
REQ-008 clr_sticky  in  1  clears both sticky overflow flags.
REQ-009 mul_p  out  16  combinational signed Q7.8 product.
REQ-010 add_s  out  16  combinational signed Q7.8 sum.
REQ-011 mul_ovf, add_ovf  out  1 each  combinational overflow indications for mul_p and add_s.
REQ-012 mul_q, add_q  out  16 each  registered copies of mul_p and add_s.
REQ-013 out_valid  out  1  mul_q and add_q hold a result captured on the previous edge.
REQ-014 mul_ovf_sticky, add_ovf_sticky  out  1 each  latched overflow flags.

Function
REQ-015 Multiply: form the 32-bit signed product mul_a*mul_b (Q15.16), then scale by 2^-8 to Q7.8.
REQ-016 Multiply scaling with ROUND=1: add 0x80 to the 32-bit product, then arithmetic-shift right by 8.
REQ-017 Multiply scaling with ROUND=0: arithmetic-shift right by 8 only.
REQ-018 Multiply overflow: mul_ovf=1 when the scaled value lies outside [-32768, 32767].
REQ-019 Multiply result: with SATURATE=1, mul_p is clamped to 0x7FFF or 0x8000 on overflow; otherwise mul_p is the low 16 bits of the scaled value.
REQ-020 Add: compute the 17-bit signed sum add_a+add_b.
REQ-021 Add overflow: add_ovf=1 when bits 16 and 15 of the 17-bit sum differ.
REQ-022 Add result: with SATURATE=1, add_s is clamped to 0x7FFF (positive overflow) or 0x8000 (negative overflow); otherwise add_s is the low 16 bits of the sum.
REQ-023 mul_p, add_s, mul_ovf and add_ovf are purely combinational, with zero latency from the operands.
REQ-024 Capture: on a rising edge with in_valid=1, mul_q<=mul_p and add_q<=add_s; with in_valid=0, both hold their values.
REQ-025 out_valid is in_valid registered, giving 1-cycle latency; there is no backpressure.
REQ-026 Sticky flags: on an edge with in_valid=1 and mul_ovf=1, mul_ovf_sticky is set to 1; add_ovf_sticky is set the same way from add_ovf.
REQ-027 Sticky clear: clr_sticky=1 clears both sticky flags on the edge.
REQ-028 Simultaneous set and clear on the same edge: the set wins.
REQ-029 Overflow on cycles with in_valid=0 is ignored by the sticky flags.

Reset
REQ-030 rst=1 at a rising edge sets mul_q, add_q, out_valid and both sticky flags to 0, overriding in_valid and clr_sticky.
REQ-031 Reset asserted mid-stream discards the pending result: out_valid=0 on the following cycle.
REQ-032 The combinational outputs are unaffected by rst.

Verification
REQ-033 Basic multiply: mul_a=0x0180 (1.5), mul_b=0x0200 (2.0), in_valid=1 -> mul_p=0x0300 and mul_ovf=0; one edge later mul_q=0x0300 and out_valid=1.
REQ-034 Signed multiply and rounding: 0xFF00*0x0080 -> 0xFF80; 0x0001*0x0080 -> 0x0001 (ROUND=1) or 0x0000 (ROUND=0); 0x0001*0x0001 -> 0x0000.
REQ-035 Multiply saturation: 0x7FFF*0x0200 -> 0x7FFF with mul_ovf=1; 0x8000*0x8000 -> 0x7FFF with mul_ovf=1; mul_ovf_sticky=1 after the edge.
REQ-036 Add saturation: 0x7000+0x7000 -> 0x7FFF with add_ovf=1; 0x8000+0xFFFF -> 0x8000 with add_ovf=1; 0x0100+0xFF80 -> 0x0080 with add_ovf=0.
REQ-037 Sticky precedence: overflow with in_valid=1 and clr_sticky=1 on the same edge -> sticky flag reads 1; clr_sticky alone on the next edge -> 0.
REQ-038 Reset mid-stream: in_valid=1 continuously, rst pulsed for one edge -> all registered outputs are 0 on the next cycle, and capture resumes on the first edge after rst deasserts.

Source files
------------

// File: rtl/q78_arith.sv
// q78_arith: signed Q7.8 multiply and add with optional saturation/rounding, registered copies and sticky overflow flags.
module q78_arith #(
  parameter int SATURATE = 1,
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  input  logic [15:0] add_a,
  input  logic [15:0] add_b,
  input  logic        clr_sticky,
  output logic [15:0] mul_p,
  output logic [15:0] add_s,
  output logic        mul_ovf,
  output logic        add_ovf,
  output logic [15:0] mul_q,
  output logic [15:0] add_q,
  output logic        out_valid,
  output logic        mul_ovf_sticky,
  output logic        add_ovf_sticky
);
  logic signed [31:0] prod, rnd, sh;
  logic        [16:0] sum;
  always_comb begin
    prod = $signed(mul_a) * $signed(mul_b);
    rnd = prod + ((ROUND != 0) ? 32'sd128 : 32'sd0);
    sh = rnd >>> 8;
    mul_ovf = !((&sh[31:15]) || !(|sh[31:15]));
    mul_p = (SATURATE != 0 && mul_ovf) ? (sh[31] ? 16'h8000 : 16'h7fff) : sh[15:0];
    sum = {add_a[15], add_a} + {add_b[15], add_b};
    add_ovf = sum[16] ^ sum[15];
    add_s = (SATURATE != 0 && add_ovf) ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0];
  end
  // set beats clear so an overflow captured on a clearing edge is never lost
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q <= '0;
      add_q <= '0;
      out_valid <= 1'b0;
      mul_ovf_sticky <= 1'b0;
      add_ovf_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        mul_q <= mul_p;
        add_q <= add_s;
      end
      mul_ovf_sticky <= (in_valid && mul_ovf) || (mul_ovf_sticky && !clr_sticky);
      add_ovf_sticky <= (in_valid && add_ovf) || (add_ovf_sticky && !clr_sticky);
    end
  end
endmodule

// File: tb/tb_q78_arith.sv
// tb_q78_arith: randomized scoreboard bench for q78_arith against an integer-arithmetic reference model.
module tb_q78_arith;
  localparam int SAT = 1;
  localparam int RND = 1;
  logic clk = 0;
  logic rst = 1, in_valid = 0, clr_sticky = 0;
  logic [15:0] mul_a = 0, mul_b = 0, add_a = 0, add_b = 0;
  logic [15:0] mul_p, add_s, mul_q, add_q;
  logic mul_ovf, add_ovf, out_valid, mul_ovf_sticky, add_ovf_sticky;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] sb[$];
  logic e_ov = 0, e_ms = 0, e_as = 0;

  q78_arith #(.SATURATE(SAT), .ROUND(RND)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .mul_a(mul_a), .mul_b(mul_b), .add_a(add_a), .add_b(add_b),
    .clr_sticky(clr_sticky), .mul_p(mul_p), .add_s(add_s),
    .mul_ovf(mul_ovf), .add_ovf(add_ovf), .mul_q(mul_q), .add_q(add_q),
    .out_valid(out_valid), .mul_ovf_sticky(mul_ovf_sticky), .add_ovf_sticky(add_ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value-level model: exact product, floor division by 256, then range test.
  function automatic void model_mul(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] p, output logic o);
    int x, y, pr, q;
    x = $signed(a);
    y = $signed(b);
    pr = x * y + (RND != 0 ? 128 : 0);
    q = pr / 256;
    if (pr < 0 && pr % 256 != 0) q = q - 1;
    o = (q > 32767) || (q < -32768);
    p = (SAT != 0 && o) ? ((q > 0) ? 16'h7fff : 16'h8000) : q[15:0];
  endfunction

  function automatic void model_add(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] s, output logic o);
    int t;
    t = int'($signed(a)) + int'($signed(b));
    o = (t > 32767) || (t < -32768);
    s = (SAT != 0 && o) ? ((t > 0) ? 16'h7fff : 16'h8000) : t[15:0];
  endfunction

  task automatic step(input bit v, input logic [15:0] ma, input logic [15:0] mb,
                      input logic [15:0] aa, input logic [15:0] ab, input bit c, input bit r);
    logic [15:0] ep, es;
    logic eo, eao;
    in_valid = v; mul_a = ma; mul_b = mb; add_a = aa; add_b = ab; clr_sticky = c; rst = r;
    model_mul(ma, mb, ep, eo);
    model_add(aa, ab, es, eao);
    if (v && !r) sb.push_back({ep, es});
    @(negedge clk);
    chk("mul_p", mul_p, ep);
    chk("mul_ovf", mul_ovf, eo);
    chk("add_s", add_s, es);
    chk("add_ovf", add_ovf, eao);
    @(posedge clk);
    if (r) begin
      e_ov = 0; e_ms = 0; e_as = 0;
    end else begin
      e_ov = v;
      e_ms = (v && eo) || (e_ms && !c);
      e_as = (v && eao) || (e_as && !c);
    end
    #1;
    chk("out_valid", out_valid, e_ov);
    chk("mul_ovf_sticky", mul_ovf_sticky, e_ms);
    chk("add_ovf_sticky", add_ovf_sticky, e_as);
    if (r) begin
      chk("mul_q_rst", mul_q, 0);
      chk("add_q_rst", add_q, 0);
    end
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("mul_q", mul_q, e[31:16]);
          chk("add_q", add_q, e[15:0]);
        end
      end
    end
  end

  initial begin : driver
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 16'h0180, 16'h0200, 16'h0100, 16'hff80, 0, 1);
    step(1, 16'h0180, 16'h0200, 16'h0100, 16'hff80, 0, 0);
    step(1, 16'hff00, 16'h0080, 16'h7000, 16'h7000, 0, 0);
    step(1, 16'h0001, 16'h0080, 16'h8000, 16'hffff, 1, 0);
    step(1, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0, 0);
    step(1, 16'h7fff, 16'h0200, 16'h0000, 16'h0001, 0, 0);
    step(1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 0, 0);
    step(1, 16'h0100, 16'h0100, 16'h0010, 16'h0020, 0, 0);
    step(1, 16'h0200, 16'h0100, 16'h0030, 16'h0040, 0, 1);
    step(1, 16'h0300, 16'h0100, 16'h0050, 16'h0060, 0, 0);
    step(1, 16'h0400, 16'h0100, 16'h0070, 16'h0080, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] o[4];
      for (int k = 0; k < 4; k++)
        o[k] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
      step($urandom_range(0, 3) != 0, o[0], o[1], o[2], o[3],
           $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
